// File: rtl/tile_loader_pkg.sv
//------------------------------------------------------------------------------
// tile_loader_pkg
// Shared constants and FSM state encoding for the tile loader.
//   DEF_DATA_WIDTH  : element width (IEEE-754 double bit pattern, opaque)
//   DEF_M           : default tile edge in elements
//   DEF_ADDR_WIDTH  : default byte address width
//   BYTES_PER_ELEM  : byte stride between consecutive elements
//   OFFSET_WIDTH    : width at which the address arithmetic is evaluated
//   state_e         : loader FSM states
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package tile_loader_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_M          = 3;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int BYTES_PER_ELEM = 8;
  localparam int OFFSET_WIDTH   = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/tile_addr_gen.sv
//------------------------------------------------------------------------------
// tile_addr_gen
// Registered address / bounds generator for one tile element.
//   clk, reset           : clock, synchronous active-low reset
//   base_addr            : latched byte address of matrix element (0,0)
//   rows, cols           : latched matrix dimensions (cols = row stride)
//   tile_row, tile_col   : latched tile origin
//   i, j                 : current element coordinates inside the tile
//   in_range             : element (i,j) lies inside the matrix
//   addr                 : byte address of element (i,j), wrapped to ADDR_WIDTH
// Outputs are registered, so they reflect (i,j) one cycle after it changes.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tile_addr_gen
  import tile_loader_pkg::*;
#(
  parameter int M          = DEF_M,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int IDX_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [7:0]            rows,
  input  logic [7:0]            cols,
  input  logic [7:0]            tile_row,
  input  logic [7:0]            tile_col,
  input  logic [IDX_W-1:0]      i,
  input  logic [IDX_W-1:0]      j,
  output logic                  in_range,
  output logic [ADDR_WIDTH-1:0] addr
);

  // One extra bit so tile origins near 255 cannot alias back into range.
  logic [8:0]              row_pos;
  logic [8:0]              col_pos;
  logic [OFFSET_WIDTH-1:0] elem_off;
  logic [OFFSET_WIDTH-1:0] byte_addr;

  always_comb begin
    row_pos   = {1'b0, tile_row} + 9'(i);
    col_pos   = {1'b0, tile_col} + 9'(j);
    elem_off  = OFFSET_WIDTH'(row_pos) * OFFSET_WIDTH'(cols) + OFFSET_WIDTH'(col_pos);
    // Sum is evaluated at OFFSET_WIDTH bits and then truncated, which gives
    // the modulo-2^ADDR_WIDTH wrap on the bus address.
    byte_addr = OFFSET_WIDTH'(base_addr)
              + elem_off * OFFSET_WIDTH'(BYTES_PER_ELEM);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      in_range <= 1'b0;
      addr     <= '0;
    end else begin
      in_range <= (row_pos < {1'b0, rows}) && (col_pos < {1'b0, cols});
      addr     <= byte_addr[ADDR_WIDTH-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/tile_loader.sv
//------------------------------------------------------------------------------
// tile_loader
// Loads an M x M tile of a row-major matrix of 64-bit elements from memory,
// one read at a time, zero-padding elements that fall outside the matrix.
//   clk, reset                 : clock, synchronous active-low reset
//   start                      : one-cycle load request (accepted in IDLE)
//   base_addr, rows, cols      : matrix description, latched on start
//   tile_row, tile_col         : tile origin, latched on start
//   mem_rd_req, mem_addr       : read request / byte address (held to grant)
//   mem_gnt                    : request accepted when high with mem_rd_req
//   mem_rd_valid, mem_rd_data  : read response
//   busy, done, tile_valid     : status; done is a one-cycle pulse
//   tile_data                  : element (i,j) at [(i*M+j)*DATA_WIDTH +: DATA_WIDTH]
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tile_loader
  import tile_loader_pkg::*;
#(
  parameter int M          = DEF_M,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [7:0]                   rows,
  input  logic [7:0]                   cols,
  input  logic [7:0]                   tile_row,
  input  logic [7:0]                   tile_col,
  output logic                         mem_rd_req,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic                         mem_gnt,
  input  logic                         mem_rd_valid,
  input  logic [DATA_WIDTH-1:0]        mem_rd_data,
  output logic                         busy,
  output logic                         done,
  output logic                         tile_valid,
  output logic [M*M*DATA_WIDTH-1:0]    tile_data
);

  localparam int               IDX_W    = (M > 1) ? $clog2(M) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(M - 1);

  state_e                  state;
  logic                    phase;      // CHECK sub-cycle: 0 = wait for generator
  logic [IDX_W-1:0]        i;
  logic [IDX_W-1:0]        j;
  logic [ADDR_WIDTH-1:0]   latched_base;
  logic [7:0]              latched_rows;
  logic [7:0]              latched_cols;
  logic [7:0]              latched_tile_row;
  logic [7:0]              latched_tile_col;

  logic                    in_range;
  logic                    advance;
  logic [DATA_WIDTH-1:0]   wr_data;
  int                      elem_idx;

  tile_addr_gen #(
    .M          (M),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (IDX_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .base_addr (latched_base),
    .rows      (latched_rows),
    .cols      (latched_cols),
    .tile_row  (latched_tile_row),
    .tile_col  (latched_tile_col),
    .i         (i),
    .j         (j),
    .in_range  (in_range),
    .addr      (mem_addr)
  );

  // An element is finished either by padding (second CHECK cycle, out of
  // range) or by its read response. Responses outside WAIT never land here,
  // which also drops stale data from a request aborted by reset.
  always_comb begin
    advance  = 1'b0;
    wr_data  = '0;
    elem_idx = int'(i) * M + int'(j);
    if (state == ST_CHECK && phase && !in_range) begin
      advance = 1'b1;
    end else if (state == ST_WAIT && mem_rd_valid) begin
      advance = 1'b1;
      wr_data = mem_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= ST_IDLE;
      phase            <= 1'b0;
      i                <= '0;
      j                <= '0;
      latched_base     <= '0;
      latched_rows     <= '0;
      latched_cols     <= '0;
      latched_tile_row <= '0;
      latched_tile_col <= '0;
      mem_rd_req       <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      tile_valid       <= 1'b0;
      tile_data        <= '0;
    end else begin
      done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            latched_base     <= base_addr;
            latched_rows     <= rows;
            latched_cols     <= cols;
            latched_tile_row <= tile_row;
            latched_tile_col <= tile_col;
            tile_valid       <= 1'b0;
            busy             <= 1'b1;
            i                <= '0;
            j                <= '0;
            phase            <= 1'b0;
            state            <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          // The generator is registered: the first cycle lets it settle on
          // the new (i,j), the second acts on its range flag.
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (in_range) begin
              mem_rd_req <= 1'b1;
              state      <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            mem_rd_req <= 1'b0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Completion is handled by the advance logic below.
        end
        ST_DONE: begin
          done       <= 1'b1;
          tile_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (advance) begin
        tile_data[elem_idx*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
        if (j == LAST_IDX) begin
          j <= '0;
          if (i == LAST_IDX) begin
            state <= ST_DONE;
          end else begin
            i     <= i + 1'b1;
            state <= ST_CHECK;
          end
        end else begin
          j     <= j + 1'b1;
          state <= ST_CHECK;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tile_loader.sv
//------------------------------------------------------------------------------
// tb_tile_loader
// Directed testbench for tile_loader with a behavioural memory responder
// (programmable grant delay and response latency).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_tile_loader;

  localparam int M  = 3;
  localparam int AW = 16;
  localparam int DW = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [7:0]        rows = '0;
  logic [7:0]        cols = '0;
  logic [7:0]        tile_row = '0;
  logic [7:0]        tile_col = '0;
  logic              mem_gnt = 1'b0;
  logic              mem_rd_valid = 1'b0;
  logic [DW-1:0]     mem_rd_data = '0;
  logic              mem_rd_req;
  logic [AW-1:0]     mem_addr;
  logic              busy;
  logic              done;
  logic              tile_valid;
  logic [M*M*DW-1:0] tile_data;

  int checks   = 0;
  int failures = 0;

  tile_loader #(.M(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .rows         (rows),
    .cols         (cols),
    .tile_row     (tile_row),
    .tile_col     (tile_col),
    .mem_rd_req   (mem_rd_req),
    .mem_addr     (mem_addr),
    .mem_gnt      (mem_gnt),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .busy         (busy),
    .done         (done),
    .tile_valid   (tile_valid),
    .tile_data    (tile_data)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [0:8191];
  int            gnt_delay = 0;
  int            rsp_delay = 1;
  logic [AW-1:0] req_q[$];
  int            addr_unstable = 0;

  initial begin : responder
    logic [AW-1:0] pend_addr;
    logic [AW-1:0] held_addr;
    bit            holding;
    bit            gnt_prev;
    int            cd;
    int            wcnt;
    pend_addr = '0; held_addr = '0; holding = 0; gnt_prev = 0; cd = 0; wcnt = 0;
    forever begin
      @(negedge clk);
      mem_rd_valid = 1'b0;
      mem_gnt      = 1'b0;
      if (gnt_prev) cd = rsp_delay;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = mem[pend_addr[15:3]];
        end
      end
      if (mem_rd_req && !gnt_prev) begin
        if (holding && mem_addr !== held_addr) addr_unstable++;
        if (!holding) begin holding = 1; held_addr = mem_addr; end
        if (wcnt >= gnt_delay) begin
          mem_gnt   = 1'b1;
          pend_addr = mem_addr;
          req_q.push_back(mem_addr);
          wcnt      = 0;
          holding   = 0;
        end else begin
          wcnt++;
        end
      end else if (!mem_rd_req) begin
        holding = 0;
        wcnt    = 0;
      end
      gnt_prev = mem_gnt;
    end
  end

  // ---------------- expected-value model ----------------
  // Matrix is 5 columns wide; element k holds (k+1).0 at base 0 and base 512.
  function automatic logic [DW-1:0] exp_elem(int tr, int tc, int nr, int nc, int i, int j);
    int r, c;
    r = tr + i;
    c = tc + j;
    if (r >= nr || c >= nc) return '0;
    return $realtobits(real'(r * nc + c + 1));
  endfunction

  function automatic logic [DW-1:0] elem(int i, int j);
    return tile_data[(i*M+j)*DW +: DW];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_start(input logic [AW-1:0] b, input logic [7:0] r, input logic [7:0] c,
                          input logic [7:0] tr, input logic [7:0] tc);
    @(negedge clk);
    base_addr = b; rows = r; cols = c; tile_row = tr; tile_col = tc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles until done (bounded), flags any non-busy cycle before it,
  // then watches a few more cycles for extra done pulses.
  task automatic wait_done(input int budget, output int cyc, output int dones, output bit busy_ok);
    cyc = 0; dones = 0; busy_ok = 1;
    while (dones == 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done) dones++;
      else if (!busy) busy_ok = 0;
    end
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_rd_req, busy, done, tile_valid} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000", {mem_rd_req, busy, done, tile_valid});
    end
    checks++;
    if (mem_addr !== '0) begin
      failures++;
      $display("FAIL reset_addr got=%h want=0000", mem_addr);
    end
    checks++;
    if (tile_data !== '0) begin
      failures++;
      $display("FAIL reset_tile_data got nonzero want=0");
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc, dones; bit bok;
    gnt_delay = 0; rsp_delay = 1; req_q.delete();
    do_start(16'd0, 8'd5, 8'd5, 8'd0, 8'd0);
    wait_done(300, cyc, dones, bok);
    checks++;
    if (dones != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d want=1", dones); end
    checks++;
    if (req_q.size() != 9) begin failures++; $display("FAIL basic_req_count got=%0d want=9", req_q.size()); end
    for (int i = 0; i < M; i++) for (int j = 0; j < M; j++) begin
      if (req_q.size() == 9) begin
        checks++;
        if (req_q[i*M+j] !== 16'((i*5 + j) * 8)) begin
          failures++;
          $display("FAIL basic_addr[%0d] got=%0d want=%0d", i*M+j, req_q[i*M+j], (i*5+j)*8);
        end
      end
      checks++;
      if (elem(i, j) !== exp_elem(0, 0, 5, 5, i, j)) begin
        failures++;
        $display("FAIL basic_elem(%0d,%0d) got=%h want=%h", i, j, elem(i, j), exp_elem(0, 0, 5, 5, i, j));
      end
    end
    checks++;
    if (tile_valid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_status tile_valid=%b busy=%b want 1,0", tile_valid, busy);
    end
  endtask

  task automatic test_edge_tile;
    int cyc, dones; bit bok;
    logic [AW-1:0] want [4];
    want = '{16'd144, 16'd152, 16'd184, 16'd192};
    gnt_delay = 0; rsp_delay = 1; req_q.delete();
    do_start(16'd0, 8'd5, 8'd5, 8'd3, 8'd3);
    wait_done(300, cyc, dones, bok);
    checks++;
    if (dones != 1) begin failures++; $display("FAIL edge_done_pulses got=%0d want=1", dones); end
    checks++;
    if (req_q.size() != 4) begin
      failures++; $display("FAIL edge_req_count got=%0d want=4", req_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (req_q[k] !== want[k]) begin
          failures++; $display("FAIL edge_addr[%0d] got=%0d want=%0d", k, req_q[k], want[k]);
        end
      end
    end
    for (int i = 0; i < M; i++) for (int j = 0; j < M; j++) begin
      checks++;
      if (elem(i, j) !== exp_elem(3, 3, 5, 5, i, j)) begin
        failures++;
        $display("FAIL edge_elem(%0d,%0d) got=%h want=%h", i, j, elem(i, j), exp_elem(3, 3, 5, 5, i, j));
      end
    end
  endtask

  task automatic test_stall;
    int cyc, dones; bit bok;
    gnt_delay = 4; rsp_delay = 3; req_q.delete(); addr_unstable = 0;
    do_start(16'd512, 8'd5, 8'd5, 8'd0, 8'd0);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy_start got=%b want=1", busy); end
    wait_done(600, cyc, dones, bok);
    checks++;
    if (dones != 1) begin failures++; $display("FAIL stall_done_pulses got=%0d want=1", dones); end
    checks++;
    if (!bok) begin failures++; $display("FAIL stall_busy_throughout got=0 want=1"); end
    checks++;
    if (addr_unstable != 0) begin failures++; $display("FAIL stall_addr_stable changes=%0d want=0", addr_unstable); end
    checks++;
    if (req_q.size() != 9) begin
      failures++; $display("FAIL stall_req_count got=%0d want=9", req_q.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (req_q[k] !== 16'(512 + ((k/3)*5 + k%3) * 8)) begin
          failures++; $display("FAIL stall_addr[%0d] got=%0d want=%0d", k, req_q[k], 512 + ((k/3)*5 + k%3)*8);
        end
      end
    end
    for (int i = 0; i < M; i++) for (int j = 0; j < M; j++) begin
      checks++;
      if (elem(i, j) !== exp_elem(0, 0, 5, 5, i, j)) begin
        failures++;
        $display("FAIL stall_elem(%0d,%0d) got=%h want=%h", i, j, elem(i, j), exp_elem(0, 0, 5, 5, i, j));
      end
    end
  endtask

  task automatic test_start_ignored;
    int cyc, dones, guard; bit bok;
    gnt_delay = 0; rsp_delay = 3; req_q.delete();
    do_start(16'd0, 8'd5, 8'd5, 8'd0, 8'd0);
    guard = 0;
    while (req_q.size() == 0 && guard < 50) begin @(negedge clk); guard++; end
    checks++;
    if (req_q.size() == 0) begin failures++; $display("FAIL ignore_first_req got=0 want=1"); end
    do_start(16'd512, 8'd5, 8'd5, 8'd1, 8'd1);  // lands while the loader waits
    wait_done(400, cyc, dones, bok);
    checks++;
    if (dones != 1) begin failures++; $display("FAIL ignore_done_pulses got=%0d want=1", dones); end
    checks++;
    if (req_q.size() != 9) begin
      failures++; $display("FAIL ignore_req_count got=%0d want=9", req_q.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (req_q[k] !== 16'(((k/3)*5 + k%3) * 8)) begin
          failures++; $display("FAIL ignore_addr[%0d] got=%0d want=%0d", k, req_q[k], ((k/3)*5 + k%3)*8);
        end
      end
    end
    for (int i = 0; i < M; i++) for (int j = 0; j < M; j++) begin
      checks++;
      if (elem(i, j) !== exp_elem(0, 0, 5, 5, i, j)) begin
        failures++;
        $display("FAIL ignore_elem(%0d,%0d) got=%h want=%h", i, j, elem(i, j), exp_elem(0, 0, 5, 5, i, j));
      end
    end
  endtask

  task automatic test_reset_abort;
    int cyc, dones, guard; bit bok;
    gnt_delay = 0; rsp_delay = 6; req_q.delete();
    do_start(16'd0, 8'd5, 8'd5, 8'd0, 8'd0);
    guard = 0;
    while (req_q.size() < 3 && guard < 200) begin @(negedge clk); guard++; end
    checks++;
    if (req_q.size() < 3) begin failures++; $display("FAIL abort_third_req got=%0d want=3", req_q.size()); end
    @(negedge clk);          // grant taken, loader now waiting
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if ({mem_rd_req, busy, done, tile_valid} !== 4'b0000 || mem_addr !== '0 || tile_data !== '0) begin
      failures++;
      $display("FAIL abort_reset_state flags=%b addr=%h want flags=0000 addr=0000 tile=0",
               {mem_rd_req, busy, done, tile_valid}, mem_addr);
    end
    repeat (8) @(negedge clk);  // stale response arrives in here
    checks++;
    if (tile_data !== '0 || tile_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_stale_ignored tile_valid=%b busy=%b want 0,0 and zero tile", tile_valid, busy);
    end
    rsp_delay = 1; req_q.delete();
    do_start(16'd0, 8'd5, 8'd5, 8'd0, 8'd0);
    wait_done(300, cyc, dones, bok);
    checks++;
    if (dones != 1 || req_q.size() != 9) begin
      failures++; $display("FAIL abort_fresh_run dones=%0d reqs=%0d want 1,9", dones, req_q.size());
    end
    for (int i = 0; i < M; i++) for (int j = 0; j < M; j++) begin
      checks++;
      if (elem(i, j) !== exp_elem(0, 0, 5, 5, i, j)) begin
        failures++;
        $display("FAIL abort_elem(%0d,%0d) got=%h want=%h", i, j, elem(i, j), exp_elem(0, 0, 5, 5, i, j));
      end
    end
  endtask

  task automatic test_wrap;
    int cyc, dones; bit bok;
    logic [AW-1:0] want [4];
    want = '{16'hFFF8, 16'h0000, 16'h0008, 16'h0020};
    gnt_delay = 0; rsp_delay = 1; req_q.delete();
    do_start(16'hFFF8, 8'd5, 8'd5, 8'd0, 8'd0);
    wait_done(300, cyc, dones, bok);
    checks++;
    if (dones != 1 || req_q.size() != 9) begin
      failures++; $display("FAIL wrap_run dones=%0d reqs=%0d want 1,9", dones, req_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (req_q[k] !== want[k]) begin
          failures++; $display("FAIL wrap_addr[%0d] got=%h want=%h", k, req_q[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_empty_matrix;
    int cyc, dones; bit bok;
    gnt_delay = 0; rsp_delay = 1; req_q.delete();
    do_start(16'd0, 8'd0, 8'd5, 8'd0, 8'd0);
    wait_done(100, cyc, dones, bok);
    checks++;
    if (cyc != 2*M*M + 1) begin failures++; $display("FAIL empty_latency got=%0d want=%0d", cyc, 2*M*M+1); end
    checks++;
    if (dones != 1) begin failures++; $display("FAIL empty_done_pulses got=%0d want=1", dones); end
    checks++;
    if (req_q.size() != 0) begin failures++; $display("FAIL empty_req_count got=%0d want=0", req_q.size()); end
    checks++;
    if (tile_data !== '0 || tile_valid !== 1'b1) begin
      failures++; $display("FAIL empty_tile tile_valid=%b want=1 and zero tile", tile_valid);
    end
  endtask

  initial begin
    for (int k = 0; k < 8192; k++) mem[k] = '0;
    for (int k = 0; k < 25; k++) begin
      mem[k]      = $realtobits(real'(k + 1));
      mem[64 + k] = $realtobits(real'(k + 1));
    end
    test_reset();
    test_basic();
    test_edge_tile();
    test_stall();
    test_start_ignored();
    test_empty_matrix();
    test_wrap();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
